ascon_inv_permutation: RTL and testbench

Iterative inverse of the ASCON-p permutation. It takes a 320-bit state and applies the inverse rounds in reverse order, one round per clock, so that ascon_inv_permutation(p^ROUNDS(S)) = S. It is used in rng_testing to invert and check permutation outputs, and as the backward-direction primitive. It uses valid/ready handshakes on both sides and holds its result until the result is accepted.

---
 rtl/ascon_inv_permutation.sv | 135 +++++++++++++
 tb/tb_ascon_inv_permutation.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_inv_permutation.sv
// Iterative inverse of the ASCON-p permutation, one inverse round per clock.
// Rounds are undone in reverse order, so feeding p^ROUNDS(S) returns S.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; state_in is captured on the accept edge
//   state_in  [319:0]     {x0, x1, x2, x3, x4}, x0 in the top 64 bits
//   out_valid / out_ready output handshake; state_out is held until accepted
//   state_out [319:0]     result, same packing as state_in
//   busy                  inverse rounds in progress
module ascon_inv_permutation #(
  parameter int ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [319:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] state_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] INV_SBOX [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

  // Round index i maps to the forward constant index k = 12 - ROUNDS + i.
  localparam logic [3:0] K_BASE = 4'(12 - ROUNDS);
  localparam logic [3:0] LAST   = 4'(ROUNDS - 1);

  function automatic logic [63:0] rotr(input logic [63:0] w, input int unsigned n);
    logic [127:0] d;
    d = {w, w} >> n;
    return d[63:0];
  endfunction

  // Sigma has order 64 over GF(2)[R]/(R^64+1), so Sigma^-1 = Sigma^63, which
  // factors into the squarings Sigma^(2^j) = I + R^(a*2^j) + R^(b*2^j), j=0..5.
  function automatic logic [63:0] sigma_inv(input logic [63:0] w,
                                            input int unsigned a,
                                            input int unsigned b);
    logic [63:0] t;
    t = w;
    for (int j = 0; j < 6; j++) begin
      t = t ^ rotr(t, (a << j) % 64) ^ rotr(t, (b << j) % 64);
    end
    return t;
  endfunction

  function automatic logic [319:0] inv_round(input logic [319:0] s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [4:0]  u;
    logic [3:0]  k;
    x0 = sigma_inv(s[319:256], 19, 28);
    x1 = sigma_inv(s[255:192], 61, 39);
    x2 = sigma_inv(s[191:128],  1,  6);
    x3 = sigma_inv(s[127:64],  10, 17);
    x4 = sigma_inv(s[63:0],     7, 41);
    for (int n = 0; n < 64; n++) begin
      u = INV_SBOX[{x0[n], x1[n], x2[n], x3[n], x4[n]}];
      x0[n] = u[4];
      x1[n] = u[3];
      x2[n] = u[2];
      x3[n] = u[1];
      x4[n] = u[0];
    end
    // Round constant is {15-k, k}; for a 4-bit k, 15-k is simply ~k.
    k = K_BASE + idx;
    x2[7:0] = x2[7:0] ^ {~k, k};
    return {x0, x1, x2, x3, x4};
  endfunction

  state_t       st;
  logic [319:0] x;
  logic [3:0]   rnd;
  logic [319:0] round_nxt;

  assign round_nxt = inv_round(x, rnd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      x         <= '0;
      rnd       <= '0;
      state_out <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            x        <= state_in;
            rnd      <= LAST;
            st       <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          x <= round_nxt;
          if (rnd == 4'd0) begin
            state_out <= round_nxt;
            st        <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            rnd <= rnd - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            st        <= IDLE;
          end
        end
        default: begin
          st        <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_inv_permutation.sv
// Bench for ascon_inv_permutation: four instances (ROUNDS = 12, 8, 6, 1) are
// checked against a forward ASCON-p model and a reference inverse that applies
// Sigma 63 times per word.
module tb_ascon_inv_permutation;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iv   [4];
  logic         ir   [4];
  logic [319:0] sin  [4];
  logic         ov   [4];
  logic         ordy [4];
  logic [319:0] sout [4];
  logic         bz   [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int R = (g == 0) ? 12 : (g == 1) ? 8 : (g == 2) ? 6 : 1;
    ascon_inv_permutation #(.ROUNDS(R)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .state_in  (sin[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .state_out (sout[g]),
      .busy      (bz[g])
    );
  end

  function automatic int rounds_of(input int d);
    return (d == 0) ? 12 : (d == 1) ? 8 : (d == 2) ? 6 : 1;
  endfunction

  // ---------------- reference model ----------------
  logic [4:0] inv_tab [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };
  logic [4:0] fwd_tab [32];
  int ra [5] = '{19, 61, 1, 10, 7};
  int rb [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] rot(input logic [63:0] w, input int n);
    logic [127:0] d;
    d = {w, w} >> n;
    return d[63:0];
  endfunction

  function automatic logic [63:0] sigma(input logic [63:0] w, input int a, input int b);
    return w ^ rot(w, a) ^ rot(w, b);
  endfunction

  function automatic logic [319:0] fwd_round(input logic [319:0] s, input int k);
    logic [63:0]  x [5];
    logic [4:0]   v, u;
    logic [319:0] r;
    for (int w = 0; w < 5; w++) x[w] = s[319-64*w -: 64];
    x[2][7:0] = x[2][7:0] ^ 8'(((15 - k) << 4) | k);
    for (int n = 0; n < 64; n++) begin
      v = {x[0][n], x[1][n], x[2][n], x[3][n], x[4][n]};
      u = fwd_tab[v];
      for (int w = 0; w < 5; w++) x[w][n] = u[4-w];
    end
    for (int w = 0; w < 5; w++) x[w] = sigma(x[w], ra[w], rb[w]);
    for (int w = 0; w < 5; w++) r[319-64*w -: 64] = x[w];
    return r;
  endfunction

  function automatic logic [319:0] inv_round_m(input logic [319:0] s, input int k);
    logic [63:0]  x [5];
    logic [4:0]   v, u;
    logic [319:0] r;
    for (int w = 0; w < 5; w++) begin
      x[w] = s[319-64*w -: 64];
      for (int m = 0; m < 63; m++) x[w] = sigma(x[w], ra[w], rb[w]);
    end
    for (int n = 0; n < 64; n++) begin
      v = {x[0][n], x[1][n], x[2][n], x[3][n], x[4][n]};
      u = inv_tab[v];
      for (int w = 0; w < 5; w++) x[w][n] = u[4-w];
    end
    x[2][7:0] = x[2][7:0] ^ 8'(((15 - k) << 4) | k);
    for (int w = 0; w < 5; w++) r[319-64*w -: 64] = x[w];
    return r;
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] s, input int rounds);
    logic [319:0] t;
    t = s;
    for (int k = 12 - rounds; k < 12; k++) t = fwd_round(t, k);
    return t;
  endfunction

  function automatic logic [319:0] inv_model(input logic [319:0] s, input int rounds);
    logic [319:0] t;
    t = s;
    for (int k = 11; k >= 12 - rounds; k--) t = inv_round_m(t, k);
    return t;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed one state to instance d with out_ready high and check latency/result.
  task automatic run_one(input int d, input logic [319:0] s, input logic [319:0] expv,
                         input string tag);
    int n;
    int lat;
    n = 0;
    while (!ir[d] && n < 50) begin step(); n++; end
    check({tag, " in_ready"}, 320'(ir[d]), 320'(1));
    sin[d]  = s;
    iv[d]   = 1'b1;
    ordy[d] = 1'b1;
    step();
    iv[d]  = 1'b0;
    sin[d] = ~s;
    lat = 1;
    if (rounds_of(d) > 1) check({tag, " busy"}, 320'(bz[d]), 320'(1));
    while (!ov[d] && lat < 40) begin step(); lat++; end
    check({tag, " latency"}, 320'(lat), 320'(rounds_of(d) + 1));
    check({tag, " state_out"}, sout[d], expv);
    step();
    check({tag, " out_valid drop"}, 320'(ov[d]), 320'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [319:0] iv_state, a_state, b_state, r, a_out;
    int n;

    for (int v = 0; v < 32; v++) fwd_tab[inv_tab[v]] = 5'(v);
    iv_state = {64'h80400c0600000000, 256'h0};

    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; sin[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset in_ready[%0d]", d), 320'(ir[d]), 320'(1));
      check($sformatf("reset out_valid[%0d]", d), 320'(ov[d]), 320'(0));
      check($sformatf("reset busy[%0d]", d), 320'(bz[d]), 320'(0));
      check($sformatf("reset state_out[%0d]", d), sout[d], 320'(0));
    end

    run_one(0, perm(320'(0), 12), 320'(0), "zero r12");
    run_one(0, perm(iv_state, 12), iv_state, "iv r12");
    run_one(1, perm(iv_state, 8), iv_state, "iv r8");
    run_one(2, perm(iv_state, 6), iv_state, "iv r6");
    run_one(3, perm(320'(0), 1), 320'(0), "zero r1");

    for (int i = 0; i < 1000; i++) begin
      r = rand_state();
      run_one(3, r, inv_model(r, 1), "rand r1");
    end
    for (int i = 0; i < 10; i++) begin
      r = rand_state();
      run_one(0, r, inv_model(r, 12), "rand r12");
      run_one(1, perm(r, 8), r, "rand r8");
    end

    // Backpressure on the ROUNDS=12 instance.
    a_state = rand_state();
    b_state = rand_state();
    ordy[0] = 1'b0;
    sin[0]  = perm(a_state, 12);
    iv[0]   = 1'b1;
    step();
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 40) begin step(); n++; end
    check("bp out_valid", 320'(ov[0]), 320'(1));
    check("bp result", sout[0], a_state);
    a_out = a_state;
    for (int c = 0; c < 20; c++) begin
      iv[0]  = c[0];
      sin[0] = perm(b_state, 12);
      step();
      check("bp hold state_out", sout[0], a_out);
      check("bp hold out_valid", 320'(ov[0]), 320'(1));
      check("bp hold in_ready", 320'(ir[0]), 320'(0));
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    step();
    check("bp release out_valid", 320'(ov[0]), 320'(0));
    check("bp release in_ready", 320'(ir[0]), 320'(1));
    run_one(0, perm(b_state, 12), b_state, "bp second");

    // Asynchronous reset in the middle of round 5.
    sin[0]  = perm(rand_state(), 12);
    iv[0]   = 1'b1;
    ordy[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    repeat (4) step();
    check("mid busy before reset", 320'(bz[0]), 320'(1));
    #3;
    rst_n = 1'b0;
    #1;
    check("mid reset in_ready", 320'(ir[0]), 320'(1));
    check("mid reset out_valid", 320'(ov[0]), 320'(0));
    check("mid reset busy", 320'(bz[0]), 320'(0));
    check("mid reset state_out", sout[0], 320'(0));
    #2;
    rst_n = 1'b1;
    run_one(0, perm(320'(0), 12), 320'(0), "zero after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
